hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Consumer-side hazard controller for the 5-stage MIPS pipeline (addu, subu, ori, lui, lw, sw, beq, j, jal, jr).
- Decodes the D-stage instruction's source registers and their Tuse.
- Tracks the destination register and Tnew of every in-flight instruction in E/M/W in its own shadow pipeline.
- Outputs the D-stage stall and the per-operand forwarding-mux selects for the D, E and M consumers.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_d  input  32  instruction currently held in the D stage.
- stall  output  1  freeze PC and the D register, and insert a bubble into E this cycle.
- fwd_rs_d  output  2  D-stage rs select: 0 RF (W is covered by RF internal bypass), 1 PC+8 of E, 2 result of M.
- fwd_rt_d  output  2  D-stage rt select, same encoding as fwd_rs_d.
- fwd_rs_e  output  2  E-stage rs select: 0 E pipeline register, 2 M result, 3 W result.
- fwd_rt_e  output  2  E-stage rt select, same encoding as fwd_rs_e.
- fwd_rt_m  output  1  M-stage rt (sw store data) select: 0 M pipeline register, 1 W result.
- stall_count  output  CNT_W  number of stall cycles since reset.

Behaviour:
- Decode of instr_d (op = [31:26], funct = [5:0]):
  - Tuse = 0: beq rs/rt; jr rs.
  - Tuse = 1: addu/subu rs/rt; ori rs; lw/sw base.
  - Tuse = 2: sw rt.
  - Every other operand has no use (Tuse = infinity).
- Destination and Tnew on entry to E:
  - jal: $31, Tnew 0.
  - addu/subu: rd, Tnew 1.
  - ori/lui: rt, Tnew 1.
  - lw: rt, Tnew 2.
  - All other instructions: dst 0, Tnew 0.
  - Unknown opcodes are treated as nop.
- Shadow entries: E, M and W, each holding {rs, rt, dst[4:0], tnew[1:0]}.
- Each cycle the entries advance:
  - W <= M, with tnew = max(tnew-1, 0).
  - M <= E, with tnew = max(tnew-1, 0).
  - E <= decode(instr_d) when stall = 0; otherwise E <= bubble (all fields 0).
- Stall (combinational):
  - Asserted iff a used source register s satisfies: s != 0, s == dst of E or M, and Tuse(s) < that entry's tnew.
  - W never causes a stall.
- D-stage forward (combinational), for a source s != 0:
  - Select 1 if E.dst == s and E.tnew == 0.
  - Else select 2 if M.dst == s and M.tnew == 0.
  - Else select 0.
  - E has priority over M (younger producer wins).
- E-stage forward, for E.rs/E.rt != 0:
  - Select 2 if M.dst matches and M.tnew == 0.
  - Else select 3 if W.dst matches.
  - Else select 0.
- M-stage forward: fwd_rt_m = 1 iff M.rt != 0 and W.dst == M.rt.
- Register $0 never matches: it never stalls and never forwards, even if an instruction targets it.
- Outputs are valid in the same cycle as instr_d; there is no added latency.
- stall_count increments on every cycle with stall = 1 and saturates at all-ones.
- Reset:
  - All entries are cleared to bubble.
  - stall_count = 0.
  - As a result, every output is 0 in the cycle after reset rises.
- Reset mid-stall: the clear takes priority over the advance; stall deasserts in the next cycle unless instr_d itself hazards against the now-empty pipeline, which it cannot.
- The bubble inserted during a stall must never forward or stall.

Test Plan:
- lw $1,0($0); addu $2,$1,$1 -> stall = 1 for exactly 1 cycle. Next cycle: addu in E, fwd_rs_e = fwd_rt_e = 3. stall_count = 1.
- lw $1; beq $1,$0 -> stall for 2 cycles. Third cycle: stall = 0, fwd_rs_d = 0 (RF bypass from W). stall_count = 2.
- addu $3,$1,$2; beq $3,$0 -> 1 stall cycle, then fwd_rs_d = 2 (from M).
- jal target; jr $31 (jr in D while jal is in E) -> stall = 0, fwd_rs_d = 1.
- lw $4; sw $4,0($0) -> no stall. When sw reaches M: fwd_rt_m = 1. Separately, ori $0,$0,5; addu $5,$0,$0 -> no stall and all forward selects 0.
- Reset asserted during the second stall cycle of the lw/beq case -> next cycle stall = 0, all selects 0, stall_count = 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage stall and forwarding-select controller for the 5-stage MIPS pipeline
// Shadows dst/tnew of the E/M/W instructions and compares against the D-stage Tuse.
module hazard_scoreboard #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             fwd_rt_m,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
  } entryT;

  entryT      decEntry;
  entryT      stageE, stageM, stageW;
  logic       rsUse, rtUse;
  logic [1:0] rsTuse, rtTuse;

  wire [5:0] op    = instr_d[31:26];
  wire [5:0] funct = instr_d[5:0];
  wire [4:0] rsF   = instr_d[25:21];
  wire [4:0] rtF   = instr_d[20:16];
  wire [4:0] rdF   = instr_d[15:11];

  // Operands without a use are stored as $0 so they can never match a producer.
  always_comb begin
    decEntry = '0;
    rsUse    = 1'b0;
    rtUse    = 1'b0;
    rsTuse   = 2'd0;
    rtTuse   = 2'd0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            rsUse = 1'b1; rsTuse = 2'd1;
            rtUse = 1'b1; rtTuse = 2'd1;
            decEntry.dst  = rdF;
            decEntry.tnew = 2'd1;
          end
          FN_JR: begin
            rsUse = 1'b1; rsTuse = 2'd0;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        rsUse = 1'b1; rsTuse = 2'd1;
        decEntry.dst  = rtF;
        decEntry.tnew = 2'd1;
      end
      OP_LUI: begin
        decEntry.dst  = rtF;
        decEntry.tnew = 2'd1;
      end
      OP_LW: begin
        rsUse = 1'b1; rsTuse = 2'd1;
        decEntry.dst  = rtF;
        decEntry.tnew = 2'd2;
      end
      OP_SW: begin
        rsUse = 1'b1; rsTuse = 2'd1;
        rtUse = 1'b1; rtTuse = 2'd2;
      end
      OP_BEQ: begin
        rsUse = 1'b1; rsTuse = 2'd0;
        rtUse = 1'b1; rtTuse = 2'd0;
      end
      OP_JAL: begin
        decEntry.dst  = 5'd31;
        decEntry.tnew = 2'd0;
      end
      default: ;
    endcase
    decEntry.rs = rsUse ? rsF : 5'd0;
    decEntry.rt = rtUse ? rtF : 5'd0;
  end

  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse, input entryT ent);
    return (src != 5'd0) && (src == ent.dst) && (tuse < ent.tnew);
  endfunction

  function automatic logic [1:0] ageTnew(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

  function automatic logic [1:0] selD(input logic [4:0] src, input entryT ente, input entryT entm);
    if (src == 5'd0)                                 return 2'd0;
    else if (src == ente.dst && ente.tnew == 2'd0)   return 2'd1;
    else if (src == entm.dst && entm.tnew == 2'd0)   return 2'd2;
    else                                             return 2'd0;
  endfunction

  function automatic logic [1:0] selE(input logic [4:0] src, input entryT entm, input entryT entw);
    if (src == 5'd0)                                 return 2'd0;
    else if (src == entm.dst && entm.tnew == 2'd0)   return 2'd2;
    else if (src == entw.dst)                        return 2'd3;
    else                                             return 2'd0;
  endfunction

  always_comb begin
    stall = (hazard(decEntry.rs, rsTuse, stageE) || hazard(decEntry.rs, rsTuse, stageM) ||
             hazard(decEntry.rt, rtTuse, stageE) || hazard(decEntry.rt, rtTuse, stageM));
    fwd_rs_d = selD(decEntry.rs, stageE, stageM);
    fwd_rt_d = selD(decEntry.rt, stageE, stageM);
    fwd_rs_e = selE(stageE.rs, stageM, stageW);
    fwd_rt_e = selE(stageE.rt, stageM, stageW);
    fwd_rt_m = (stageM.rt != 5'd0) && (stageW.dst == stageM.rt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stageE      <= '0;
      stageM      <= '0;
      stageW      <= '0;
      stall_count <= '0;
    end else begin
      stageE      <= stall ? entryT'('0) : decEntry;
      stageM      <= '{rs: stageE.rs, rt: stageE.rt, dst: stageE.dst, tnew: ageTnew(stageE.tnew)};
      stageW      <= '{rs: stageM.rs, rt: stageM.rt, dst: stageM.dst, tnew: ageTnew(stageM.tnew)};
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table-driven bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = 32'd0;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m;
  logic [31:0] stall_count;

  int nChecks = 0;
  int nFail = 0;

  hazard_scoreboard #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        stall;
    logic [1:0]  rsD, rtD, rsE, rtE;
    logic        rtM;
    int          cnt;
  } vecT;

  vecT vecs[$];

  function automatic logic [31:0] LW(input logic [4:0] rt, input logic [4:0] base);
    return {6'h23, base, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] SW(input logic [4:0] rt, input logic [4:0] base);
    return {6'h2b, base, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] ADDU(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction
  function automatic logic [31:0] SUBU(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h23};
  endfunction
  function automatic logic [31:0] BEQ(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h04, rs, rt, 16'h0004};
  endfunction
  function automatic logic [31:0] ORI(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {6'h0d, rs, rt, imm};
  endfunction
  function automatic logic [31:0] LUI(input logic [4:0] rt);
    return {6'h0f, 5'd0, rt, 16'h1234};
  endfunction
  function automatic logic [31:0] JR(input logic [4:0] rs);
    return {6'h00, rs, 15'd0, 6'h08};
  endfunction
  localparam logic [31:0] JAL = {6'h03, 26'h0000040};
  localparam logic [31:0] NOP = 32'd0;
  localparam logic [31:0] BAD = {6'h3f, 5'd31, 5'd31, 16'h0000};

  task automatic addV(input logic [31:0] instr, input logic st, input logic [1:0] rsD,
                      input logic [1:0] rtD, input logic [1:0] rsE, input logic [1:0] rtE,
                      input logic rtM, input int cnt);
    vecT v;
    v.instr = instr; v.stall = st; v.rsD = rsD; v.rtD = rtD;
    v.rsE = rsE; v.rtE = rtE; v.rtM = rtM; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] instr);
    @(posedge clk);
    #1;
    reset   = rst;
    instr_d = instr;
    @(negedge clk);
  endtask

  task automatic checkAll(input int idx, input logic st, input logic [1:0] rsD, input logic [1:0] rtD,
                          input logic [1:0] rsE, input logic [1:0] rtE, input logic rtM, input int cnt);
    check("stall",       idx, 32'(stall),    32'(st));
    check("fwd_rs_d",    idx, 32'(fwd_rs_d), 32'(rsD));
    check("fwd_rt_d",    idx, 32'(fwd_rt_d), 32'(rtD));
    check("fwd_rs_e",    idx, 32'(fwd_rs_e), 32'(rsE));
    check("fwd_rt_e",    idx, 32'(fwd_rt_e), 32'(rtE));
    check("fwd_rt_m",    idx, 32'(fwd_rt_m), 32'(rtM));
    check("stall_count", idx, stall_count,   32'(cnt));
  endtask

  initial begin
    int n;
    //   instr          st rsD rtD rsE rtE rtM cnt
    addV(NOP,           0, 0,  0,  0,  0,  0,  0);  // reset state
    addV(LW(1, 0),      0, 0,  0,  0,  0,  0,  0);
    addV(ADDU(2, 1, 1), 1, 0,  0,  0,  0,  0,  0);  // load-use stall
    addV(ADDU(2, 1, 1), 0, 0,  0,  0,  0,  0,  1);
    addV(NOP,           0, 0,  0,  3,  3,  0,  1);  // addu in E takes W result
    addV(LW(1, 0),      0, 0,  0,  0,  0,  0,  1);
    addV(BEQ(1, 0),     1, 0,  0,  0,  0,  0,  1);
    addV(BEQ(1, 0),     1, 0,  0,  0,  0,  0,  2);
    addV(BEQ(1, 0),     0, 0,  0,  0,  0,  0,  3);  // W covered by RF bypass
    addV(ADDU(3, 1, 2), 0, 0,  0,  0,  0,  0,  3);
    addV(BEQ(3, 0),     1, 0,  0,  0,  0,  0,  3);
    addV(BEQ(3, 0),     0, 2,  0,  0,  0,  0,  4);  // from M
    addV(JAL,           0, 0,  0,  3,  0,  0,  4);
    addV(JR(31),        0, 1,  0,  0,  0,  0,  4);  // PC+8 of jal in E
    addV(LW(4, 0),      0, 0,  0,  2,  0,  0,  4);
    addV(SW(4, 0),      0, 0,  0,  0,  0,  0,  4);  // store data Tuse 2: no stall
    addV(NOP,           0, 0,  0,  0,  0,  0,  4);
    addV(NOP,           0, 0,  0,  0,  0,  1,  4);  // sw in M takes W result
    addV(ORI(0, 0, 5),  0, 0,  0,  0,  0,  0,  4);
    addV(ADDU(5, 0, 0), 0, 0,  0,  0,  0,  0,  4);
    addV(LUI(6),        0, 0,  0,  0,  0,  0,  4);
    addV(SUBU(7, 6, 5), 0, 0,  2,  0,  0,  0,  4);
    addV(NOP,           0, 0,  0,  2,  3,  0,  4);
    addV(JAL,           0, 0,  0,  0,  0,  0,  4);
    addV(JAL,           0, 0,  0,  0,  0,  0,  4);
    addV(JR(31),        0, 1,  0,  0,  0,  0,  4);  // E wins over M
    addV(BAD,           0, 0,  0,  2,  0,  0,  4);
    addV(NOP,           0, 0,  0,  0,  0,  0,  4);  // unknown opcode behaves as nop

    reset = 1'b1;
    step(1'b1, NOP);
    step(1'b1, NOP);
    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].instr);
      checkAll(i, vecs[i].stall, vecs[i].rsD, vecs[i].rtD, vecs[i].rsE,
               vecs[i].rtE, vecs[i].rtM, vecs[i].cnt);
    end

    // Reset during the second stall cycle of lw/beq.
    step(1'b0, LW(1, 0));
    step(1'b0, BEQ(1, 0));
    check("rst_seq stall1", 100, 32'(stall), 32'd1);
    step(1'b1, BEQ(1, 0));
    check("rst_seq stall2", 101, 32'(stall), 32'd1);
    step(1'b0, BEQ(1, 0));
    checkAll(102, 0, 0, 0, 0, 0, 0, 0);

    // lw/beq from a fresh counter, stall length measured with a bounded loop.
    step(1'b0, LW(1, 0));
    step(1'b0, BEQ(1, 0));
    n = 0;
    while (stall === 1'b1 && n < 10) begin
      n++;
      step(1'b0, BEQ(1, 0));
    end
    check("lwbeq stall cycles", 200, 32'(n), 32'd2);
    checkAll(201, 0, 0, 0, 0, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
